pipe_adder: RTL and testbench

Parametrised, pipelined ripple-carry adder/subtractor with valid/ready handshakes on input and output.
- Splits a WIDTH-bit add into STAGES carry-linked chunks, one chunk per clock stage.
- Sustains one operation per cycle at a latency of STAGES cycles.
- Intended as the datapath adder for multi-cycle ALU and accumulator blocks. Replaces the combinational full-adder chain wherever timing needs registered stages.

---
 rtl/pipe_adder.sv | 140 ++++++++++++++
 tb/tb_pipe_adder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-wide slice per stage, valid/ready flow control.
// Optional saturation of the result on signed overflow when PIPE_ADDER_SAT_EN is defined.
module pipe_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CHUNK = WIDTH / STAGES;

   logic             adv;
   logic [WIDTH-1:0] b_eff;
   logic             c0;
   logic [WIDTH-1:0] res_raw;
   logic [WIDTH-1:0] res;
   logic             last_a_msb;
   logic             last_b_msb;
   logic             last_c;
   logic             ovf_raw;

   assign b_eff = sub ? ~b : b;
   assign c0    = sub | cin;

   genvar k;
   for (k = 0; k < STAGES; k++) begin : g_st
      // Stage k sees only the operand bits not yet consumed, so its operand width shrinks by CHUNK per stage.
      localparam int OW = WIDTH - k*CHUNK;

      logic [OW-1:0]    op_a;
      logic [OW-1:0]    op_b;
      logic             c_in;
      logic             a_msb;
      logic             b_msb;
      logic             vld_d;
      logic [WIDTH-1:0] s_in;
      logic [WIDTH-1:0] s_d;
      logic [CHUNK:0]   add;

      logic             vld_q;
      logic             c_q;
      logic             a_msb_q;
      logic             b_msb_q;
      logic [WIDTH-1:0] s_q;

      if (k == 0) begin : g_src
         assign op_a  = a;
         assign op_b  = b_eff;
         assign c_in  = c0;
         assign a_msb = a[WIDTH-1];
         assign b_msb = b_eff[WIDTH-1];
         assign s_in  = '0;
         assign vld_d = in_valid;
      end else begin : g_src
         assign op_a  = g_st[k-1].g_fwd.ra_q;
         assign op_b  = g_st[k-1].g_fwd.rb_q;
         assign c_in  = g_st[k-1].c_q;
         assign a_msb = g_st[k-1].a_msb_q;
         assign b_msb = g_st[k-1].b_msb_q;
         assign s_in  = g_st[k-1].s_q;
         assign vld_d = g_st[k-1].vld_q;
      end

      assign add = {1'b0, op_a[CHUNK-1:0]} + {1'b0, op_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_in};

      always_comb begin
         s_d = s_in;
         s_d[k*CHUNK +: CHUNK] = add[CHUNK-1:0];
      end

      if (k < STAGES-1) begin : g_fwd
         logic [OW-CHUNK-1:0] ra_d;
         logic [OW-CHUNK-1:0] rb_d;
         logic [OW-CHUNK-1:0] ra_q;
         logic [OW-CHUNK-1:0] rb_q;

         assign ra_d = op_a[OW-1:CHUNK];
         assign rb_d = op_b[OW-1:CHUNK];

         always_ff @(posedge clk) begin
            if (adv) begin
               ra_q <= ra_d;
               rb_q <= rb_d;
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q <= 1'b0;
         end else if (adv) begin
            vld_q <= vld_d;
         end
      end

      // Datapath registers carry no reset; outputs are gated by out_valid instead.
      always_ff @(posedge clk) begin
         if (adv) begin
            s_q     <= s_d;
            c_q     <= add[CHUNK];
            a_msb_q <= a_msb;
            b_msb_q <= b_msb;
         end
      end
   end

   assign out_valid  = g_st[STAGES-1].vld_q;
   assign res_raw    = g_st[STAGES-1].s_q;
   assign last_c     = g_st[STAGES-1].c_q;
   assign last_a_msb = g_st[STAGES-1].a_msb_q;
   assign last_b_msb = g_st[STAGES-1].b_msb_q;

   assign in_ready = !(out_valid && !out_ready);
   assign adv      = in_ready;

   assign ovf_raw = (last_a_msb == last_b_msb) && (res_raw[WIDTH-1] != last_a_msb);

`ifdef PIPE_ADDER_SAT_EN
   assign res = ovf_raw ? {last_a_msb, {(WIDTH-1){~last_a_msb}}} : res_raw;
`else
   assign res = res_raw;
`endif

   assign sum  = out_valid ? res : '0;
   assign cout = out_valid & last_c;
   assign ovf  = out_valid & ovf_raw;

endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder (WIDTH=32, STAGES=4): vector table, streaming, backpressure, mid-flight reset.
module tb_pipe_adder;

   localparam int W = 32;
   localparam int S = 4;
`ifdef PIPE_ADDER_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic        sub;
      logic [31:0] s_raw;
      logic [31:0] s_sat;
      logic        co;
      logic        ov;
   } vec_t;

   localparam int NV = 10;
   vec_t vt [NV];

   pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic run_op(input string nm, input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic tc, input logic ts, input logic [31:0] es,
                         input logic eco, input logic eov);
      @(negedge clk);
      a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int j = 1; j < S; j++) begin
         chk({nm, "_early_vld"}, 32'(out_valid), 32'd0);
         @(negedge clk);
      end
      chk({nm, "_vld"},  32'(out_valid), 32'd1);
      chk({nm, "_sum"},  sum, es);
      chk({nm, "_cout"}, 32'(cout), 32'(eco));
      chk({nm, "_ovf"},  32'(ovf), 32'(eov));
      @(negedge clk);
      chk({nm, "_vld_drop"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int sent;
      int rcv;
      logic [31:0] e;

      vt[0] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
      vt[1] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0, 1'b0};
      vt[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1};
      vt[3] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 32'h80000000, 1'b1, 1'b1};
      vt[4] = '{32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 32'h00000002, 1'b1, 1'b0};
      vt[5] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b1};
      vt[6] = '{32'h00FF00FF, 32'h00010001, 1'b0, 1'b0, 32'h01000100, 32'h01000100, 1'b0, 1'b0};
      vt[7] = '{32'h12345678, 32'h0FEDCBA9, 1'b1, 1'b0, 32'h22222222, 32'h22222222, 1'b0, 1'b0};
      vt[8] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
      vt[9] = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 32'h00010000, 1'b0, 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum", sum, 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      for (int i = 0; i < NV; i++) begin
         run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].cin, vt[i].sub,
                SAT ? vt[i].s_sat : vt[i].s_raw, vt[i].co, vt[i].ov);
      end

      // Back-to-back stream, results expected 4 cycles after each input with no gaps
      for (int c = 0; c <= 12; c++) begin
         @(negedge clk);
         if (c >= S && c < S + 8) begin
            e = 32'(c - S + 1) * 32'h00000101;
            chk("stream_vld", 32'(out_valid), 32'd1);
            chk("stream_sum", sum, e);
         end else begin
            chk("stream_idle", 32'(out_valid), 32'd0);
         end
         if (c < 8) begin
            a = 32'(c + 1); b = 32'(c + 1) << 8; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
      end

      // Same stream with out_ready low for cycles 5-7
      sent = 0;
      rcv  = 0;
      for (int c = 0; c < 40 && rcv < 8; c++) begin
         @(negedge clk);
         out_ready = !(c >= 5 && c <= 7);
         #1;
         e = 32'(rcv + 1) * 32'h00000101;
         if (c >= 5 && c <= 7) begin
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            chk("bp_hold_vld", 32'(out_valid), 32'd1);
            chk("bp_hold_sum", sum, e);
         end else begin
            chk("bp_in_ready_high", 32'(in_ready), 32'd1);
         end
         if (out_valid && out_ready) begin
            chk("bp_sum", sum, e);
            rcv++;
         end
         if (sent < 8) begin
            a = 32'(sent + 1); b = 32'(sent + 1) << 8; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            if (in_ready) sent++;
         end else begin
            in_valid = 1'b0;
         end
      end
      chk("bp_count", 32'(rcv), 32'd8);
      out_ready = 1'b1;
      in_valid  = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("bp_no_extra", 32'(out_valid), 32'd0);
      end

      // Reset with three operations in flight
      @(negedge clk);
      a = 32'h11111111; b = 32'h22222222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      a = 32'h00000001; b = 32'h00000001;
      @(negedge clk);
      a = 32'h00000005; b = 32'h00000005;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("prerst_vld", 32'(out_valid), 32'd1);
      chk("prerst_sum", sum, 32'h33333333);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_vld", 32'(out_valid), 32'd0);
      chk("midrst_sum", sum, 32'd0);
      chk("midrst_cout", 32'(cout), 32'd0);
      #1 rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("postrst_no_stale", 32'(out_valid), 32'd0);
      end
      run_op("postrst_new", 32'd1, 32'd2, 1'b0, 1'b0, 32'd3, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
